// File: rtl/gf180mcu_oai33_bist_pkg.sv
// Shared types, constants and the OAI33 reference function for the OAI33 BIST engine.
// The LFSR constants are used only when GF180MCU_OAI33_BIST_LFSR_EN is defined.
package gf180mcu_oai33_bist_pkg;

   localparam int unsigned VEC_W   = 6;
   localparam int unsigned NUM_VEC = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Fibonacci x^6+x^5+1: feedback is bit5 ^ bit4, shifted in at bit 0.
   // LFSR_LAST is the state whose successor would be the seed again.
   localparam logic [VEC_W-1:0] LFSR_SEED = 6'b000001;
   localparam logic [VEC_W-1:0] LFSR_TAPS = 6'b110000;
   localparam logic [VEC_W-1:0] LFSR_LAST = 6'b100000;

   // Vector layout is {B3,B2,B1,A3,A2,A1}.
   function automatic logic oai33_expected(input logic [VEC_W-1:0] vec);
      return !((|vec[2:0]) & (|vec[5:3]));
   endfunction

endpackage

// File: rtl/gf180mcu_oai33_bist_vecgen.sv
// Test-vector generator: holds the current vector and supports load, advance and clear.
// Ascending order by default; LFSR order when GF180MCU_OAI33_BIST_LFSR_EN is defined.
module gf180mcu_oai33_bist_vecgen
   import gf180mcu_oai33_bist_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_load,
   input  logic             i_advance,
   input  logic             i_clear,
   output logic [VEC_W-1:0] o_vec,
   output logic             o_is_last
);

   logic [VEC_W-1:0] r_vec;
   logic [VEC_W-1:0] w_first;
   logic [VEC_W-1:0] w_next;

`ifdef GF180MCU_OAI33_BIST_LFSR_EN
   // The zero vector cannot occur in the LFSR cycle, so it is appended after the last state.
   assign w_first   = LFSR_SEED;
   assign w_next    = (r_vec == LFSR_LAST) ? '0
                                           : {r_vec[VEC_W-2:0], ^(r_vec & LFSR_TAPS)};
   assign o_is_last = (r_vec == '0);
`else
   assign w_first   = '0;
   assign w_next    = r_vec + 1'b1;
   assign o_is_last = (r_vec == {VEC_W{1'b1}});
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_vec <= '0;
      end else if (i_clear) begin
         r_vec <= '0;
      end else if (i_load) begin
         r_vec <= w_first;
      end else if (i_advance) begin
         r_vec <= w_next;
      end
   end

   assign o_vec = r_vec;

endmodule

// File: rtl/gf180mcu_oai33_bist.sv
// Exhaustive stimulus/check engine for one OAI33 cell: drives A1..B3, samples ZN, reports results.
// Vector order is ascending, or LFSR-based when GF180MCU_OAI33_BIST_LFSR_EN is defined.
module gf180mcu_oai33_bist
   import gf180mcu_oai33_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ZN,
   output logic       A1,
   output logic       A2,
   output logic       A3,
   output logic       B1,
   output logic       B2,
   output logic       B3,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [6:0] ERR_CNT,
   output logic       FAIL_VLD,
   output logic [5:0] FAIL_VEC
);

   localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
   localparam logic [1:0] S_SETTLE  = 2'(ST_SETTLE);
   localparam logic [1:0] S_SAMPLE  = 2'(ST_SAMPLE);
   localparam logic [1:0] S_DONE    = 2'(ST_DONE);
   localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0]       r_state;
   logic [3:0]       r_wait;
   logic [6:0]       r_err_cnt;
   logic             r_fail_vld;
   logic [5:0]       r_fail_vec;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   logic [VEC_W-1:0] w_vec;
   logic             w_is_last;
   logic             w_load;
   logic             w_advance;
   logic             w_clear;
   logic             w_expected;
   logic             w_mismatch;

   assign w_load     = START && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_advance  = (r_state == S_SAMPLE) && !w_is_last;
   assign w_clear    = (r_state == S_SAMPLE) && w_is_last;
   assign w_expected = oai33_expected(w_vec);
   // Case inequality so an X or Z on ZN counts as a failure instead of a silent pass.
   assign w_mismatch = (ZN !== w_expected);

   gf180mcu_oai33_bist_vecgen u_vecgen (
      .CLK       (CLK),
      .RST       (RST),
      .i_load    (w_load),
      .i_advance (w_advance),
      .i_clear   (w_clear),
      .o_vec     (w_vec),
      .o_is_last (w_is_last)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_wait     <= '0;
         r_err_cnt  <= '0;
         r_fail_vld <= 1'b0;
         r_fail_vec <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (START) begin
                  r_state    <= S_SETTLE;
                  r_wait     <= '0;
                  r_err_cnt  <= '0;
                  r_fail_vld <= 1'b0;
                  r_fail_vec <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
               end else if (r_state == S_DONE) begin
                  // Error count is final by now, so PASS can be derived from it.
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
                  r_pass <= (r_err_cnt == '0);
               end
            end
            S_SETTLE: begin
               if (r_wait == WAIT_LAST) begin
                  r_wait  <= '0;
                  r_state <= S_SAMPLE;
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end
            S_SAMPLE: begin
               if (w_mismatch) begin
                  r_err_cnt <= r_err_cnt + 7'd1;
                  if (!r_fail_vld) begin
                     r_fail_vld <= 1'b1;
                     r_fail_vec <= w_vec;
                  end
               end
               r_state <= w_is_last ? S_DONE : S_SETTLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign A1       = w_vec[0];
   assign A2       = w_vec[1];
   assign A3       = w_vec[2];
   assign B1       = w_vec[3];
   assign B2       = w_vec[4];
   assign B3       = w_vec[5];
   assign BUSY     = r_busy;
   assign DONE     = r_done;
   assign PASS     = r_pass;
   assign ERR_CNT  = r_err_cnt;
   assign FAIL_VLD = r_fail_vld;
   assign FAIL_VEC = r_fail_vec;

endmodule

// File: tb/tb_gf180mcu_oai33_bist.sv
// Directed bench for gf180mcu_oai33_bist with a behavioural OAI33 cell and fault modes on ZN.
// Honours GF180MCU_OAI33_BIST_LFSR_EN for the vector-order and first-failure expectations.
module tb_gf180mcu_oai33_bist;

   localparam int SETTLE   = 2;
   localparam int PER_VEC  = SETTLE + 1;
   localparam int DONE_LAT = 64 * PER_VEC + 1;

`ifdef GF180MCU_OAI33_BIST_LFSR_EN
   localparam logic [5:0] T1_FAIL_VEC = 6'b100001;
   localparam logic [5:0] T0_FAIL_VEC = 6'b000001;
`else
   localparam logic [5:0] T1_FAIL_VEC = 6'b001001;
   localparam logic [5:0] T0_FAIL_VEC = 6'b000000;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic       ZN;
   logic       A1, A2, A3, B1, B2, B3;
   logic       BUSY, DONE, PASS, FAIL_VLD;
   logic [6:0] ERR_CNT;
   logic [5:0] FAIL_VEC;

   int   n_checks = 0;
   int   n_errors = 0;
   int   zn_mode  = 0;
   logic four_state;
   logic x_probe;

   logic [5:0]  w_vec;
   logic        w_ideal;
   logic [22:0] w_all_out;

   assign w_vec     = {B3, B2, B1, A3, A2, A1};
   assign w_ideal   = ~((A1 | A2 | A3) & (B1 | B2 | B3));
   assign w_all_out = {w_vec, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC};

   // Mode 3 drives X on vector 37; a 2-state simulator gets the inverted value instead.
   always_comb begin
      case (zn_mode)
         1:       ZN = 1'b1;
         2:       ZN = 1'b0;
         3:       ZN = (w_vec == 6'd37) ? (four_state ? 1'bx : ~w_ideal) : w_ideal;
         default: ZN = w_ideal;
      endcase
   end

   always #5 CLK = ~CLK;

   gf180mcu_oai33_bist #(.SETTLE_CYCLES(SETTLE)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .ZN       (ZN),
      .A1       (A1),
      .A2       (A2),
      .A3       (A3),
      .B1       (B1),
      .B2       (B2),
      .B3       (B3),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .PASS     (PASS),
      .ERR_CNT  (ERR_CNT),
      .FAIL_VLD (FAIL_VLD),
      .FAIL_VEC (FAIL_VEC)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // One full run from a START pulse; optionally re-pulses START at cycle restart_at.
   task automatic run_vectors(input string tag, input int restart_at,
                              input logic [6:0] exp_err, input logic exp_vld,
                              input logic [5:0] exp_fv);
      logic [5:0]  seq [64];
      logic [63:0] seen;
      int          n;
      int          bad;
      int          distinct;
      @(posedge CLK); #1 START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      check({tag, "/busy_next"}, 32'(BUSY), 32'd1);
      check({tag, "/done_low"},  32'(DONE), 32'd0);
      for (int i = 0; i < 64; i++) seq[i] = 6'bx;
      n = 0;
      while (DONE !== 1'b1 && n < DONE_LAT + 20) begin
         if ((n % PER_VEC) == 1 && (n / PER_VEC) < 64) seq[n / PER_VEC] = w_vec;
         START = (n == restart_at);
         @(posedge CLK); #1;
         n++;
      end
      START = 1'b0;
      check({tag, "/done_cycle"}, 32'(n),        32'(DONE_LAT));
      check({tag, "/busy_end"},   32'(BUSY),     32'd0);
      check({tag, "/pass"},       32'(PASS),     32'(exp_err == 7'd0));
      check({tag, "/err_cnt"},    32'(ERR_CNT),  32'(exp_err));
      check({tag, "/fail_vld"},   32'(FAIL_VLD), 32'(exp_vld));
      check({tag, "/fail_vec"},   32'(FAIL_VEC), 32'(exp_fv));
      check({tag, "/ab_zero"},    32'(w_vec),    32'd0);
`ifdef GF180MCU_OAI33_BIST_LFSR_EN
      seen     = '0;
      distinct = 0;
      for (int i = 0; i < 64; i++) begin
         if (!$isunknown(seq[i]) && !seen[seq[i]]) begin
            seen[seq[i]] = 1'b1;
            distinct++;
         end
      end
      bad = 0;
      check({tag, "/distinct"},  32'(distinct), 32'd64);
      check({tag, "/last_zero"}, 32'(seq[63]),  32'd0);
      check({tag, "/first"},     32'(seq[0]),   32'd1);
`else
      bad = 0;
      seen = '0;
      distinct = 0;
      for (int i = 0; i < 64; i++) if (seq[i] !== 6'(i)) bad++;
      check({tag, "/order"}, 32'(bad), 32'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      x_probe    = 1'bx;
      four_state = $isunknown(x_probe);
      RST   = 1'b1;
      START = 1'b0;
      repeat (3) @(posedge CLK);
      #1 check("reset/outputs", 32'(w_all_out), 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;
      check("idle/outputs", 32'(w_all_out), 32'd0);

      zn_mode = 0;
      run_vectors("ideal", -1, 7'd0, 1'b0, 6'd0);

      zn_mode = 1;
      run_vectors("tie1", -1, 7'd49, 1'b1, T1_FAIL_VEC);
      check("tie1/done_held", 32'(DONE), 32'd1);

      zn_mode = 2;
      run_vectors("tie0", -1, 7'd15, 1'b1, T0_FAIL_VEC);

      zn_mode = 3;
      run_vectors("x37", -1, 7'd1, 1'b1, 6'd37);

      zn_mode = 0;
      run_vectors("restart_ignored", 60, 7'd0, 1'b0, 6'd0);

      // Abort mid-run: reset must clear everything without waiting for a clock edge.
      @(posedge CLK); #1 START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      repeat (50) @(posedge CLK);
      #1 RST = 1'b1;
      #2 check("abort/async_clear", 32'(w_all_out), 32'd0);
      START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      RST = 1'b0;
      repeat (4) @(posedge CLK);
      #1 check("abort/start_in_reset_ignored", 32'(w_all_out), 32'd0);
      repeat (200) @(posedge CLK);
      #1 check("abort/no_partial_done", 32'(DONE), 32'd0);

      run_vectors("after_abort", -1, 7'd0, 1'b0, 6'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
